// File: rtl/maxmin_reducer_pkg.sv
// Shared state encoding and default geometry for the max/min reduction block.
// No logic; state constants kept as plain localparams for legacy tooling.
package maxmin_reducer_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_LEN_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ACCUM = 2'd1;
  localparam state_t S_DONE  = 2'd2;

endpackage

// File: rtl/maxmin_reducer_ext_cmp.sv
// Combinational "b strictly better than a" compare, zero latency, no flow control.
// Signed or unsigned, min or max, always over the full WIDTH bits.
module ext_cmp
  import maxmin_reducer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  input  logic             is_min,
  output logic             better
);

  logic b_lt_a;
  logic b_gt_a;

  always_comb begin
    b_lt_a = 1'b0;
    b_gt_a = 1'b0;
    if (is_signed) begin
      b_lt_a = $signed(b) < $signed(a);
      b_gt_a = $signed(b) > $signed(a);
    end else begin
      b_lt_a = b < a;
      b_gt_a = b > a;
    end
  end

  // Strict compare so ties keep the earlier element.
  assign better = is_min ? b_lt_a : b_gt_a;

endmodule

// File: rtl/maxmin_reducer.sv
// Streams len elements and reports the extreme value and its index; result valid the cycle after the last beat.
// Input stalls on in_valid gaps; the result is held in DONE until out_ready, start ignored while busy.
module maxmin_reducer
  import maxmin_reducer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LEN_W = DEFAULT_LEN_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             is_signed,
  input  logic             is_min,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic [LEN_W-1:0] out_index,
  output logic             out_empty
);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic             signed_q;
  logic             min_q;
  logic [LEN_W-1:0] cnt;
  logic             better;
  logic             accept;

  assign busy      = (state != S_IDLE);
  assign in_ready  = (state == S_ACCUM);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;

  ext_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a         (out_value),
    .b         (in_data),
    .is_signed (signed_q),
    .is_min    (min_q),
    .better    (better)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      len_q     <= '0;
      signed_q  <= 1'b0;
      min_q     <= 1'b0;
      cnt       <= '0;
      out_value <= '0;
      out_index <= '0;
      out_empty <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q     <= len;
            signed_q  <= is_signed;
            min_q     <= is_min;
            cnt       <= '0;
            out_value <= '0;
            out_index <= '0;
            out_empty <= (len == '0);
            state     <= (len == '0) ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            // First beat seeds the result regardless of the compare.
            if (cnt == '0 || better) begin
              out_value <= in_data;
              out_index <= cnt;
            end
            out_empty <= 1'b0;
            cnt       <= cnt + LEN_W'(1);
            // Compare before incrementing so len = all-ones never wraps.
            if (cnt == len_q - LEN_W'(1)) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxmin_reducer.sv
// Bench for maxmin_reducer: vector table plus corner sequences, results checked via scoreboard queue.
module tb_maxmin_reducer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        is_signed = 1'b0;
  logic        is_min = 1'b0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_value;
  logic [7:0]  out_index;
  logic        out_empty;

  always #5 clk = ~clk;

  maxmin_reducer #(.WIDTH(32), .LEN_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .len       (len),
    .is_signed (is_signed),
    .is_min    (is_min),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_index (out_index),
    .out_empty (out_empty)
  );

  typedef struct {
    logic [31:0] v;
    logic [7:0]  i;
    logic        e;
  } exp_t;

  typedef struct {
    logic             sgn;
    logic             mn;
    logic [7:0]       ln;
    logic [3:0][31:0] d;
    int               gap;
    logic [31:0]      ev;
    logic [7:0]       ei;
    logic             ee;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[9];
  logic [31:0] stim[256];
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic sgn, input logic mn, input logic [7:0] ln,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3, input int gap,
                              input logic [31:0] ev, input logic [7:0] ei, input logic ee);
    vec_t r;
    r.sgn = sgn; r.mn = mn; r.ln = ln;
    r.d[0] = d0; r.d[1] = d1; r.d[2] = d2; r.d[3] = d3;
    r.gap = gap; r.ev = ev; r.ei = ei; r.ee = ee;
    return r;
  endfunction

  // Reference reduction over stim[0..ln-1].
  function automatic exp_t model(input logic sgn, input logic mn, input int ln);
    exp_t r;
    logic take;
    r.v = '0; r.i = '0; r.e = (ln == 0);
    for (int k = 0; k < ln; k++) begin
      if (k == 0) take = 1'b1;
      else if (sgn) take = mn ? ($signed(stim[k]) < $signed(r.v)) : ($signed(stim[k]) > $signed(r.v));
      else take = mn ? (stim[k] < r.v) : (stim[k] > r.v);
      if (take) begin
        r.v = stim[k];
        r.i = k[7:0];
      end
    end
    return r;
  endfunction

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check("idle_before_start", busy, 0);
  endtask

  task automatic collect();
    exp_t e;
    int   k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check("out_valid_seen", out_valid, 1);
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard: result with no expectation queued");
    end else begin
      e = sb.pop_front();
      check("out_value", out_value, e.v);
      check("out_index", out_index, e.i);
      check("out_empty", out_empty, e.e);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("idle_after_handshake", {busy, out_valid}, 0);
      check("value_retained_idle", out_value, e.v);
    end
  endtask

  task automatic run(input logic sgn, input logic mn, input logic [7:0] ln, input int gap,
                     input logic [31:0] ev, input logic [7:0] ei, input logic ee);
    int   k;
    exp_t e;
    wait_idle();
    start = 1'b1; len = ln; is_signed = sgn; is_min = mn;
    @(posedge clk); #1;
    start = 1'b0;
    e.v = ev; e.i = ei; e.e = ee;
    sb.push_back(e);
    for (int b = 0; b < int'(ln); b++) begin
      repeat (gap) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = stim[b];
      k = 0;
      while (!in_ready && k < 20) begin
        @(posedge clk); #1; k++;
      end
      if (!in_ready) begin
        n_total++;
        $display("FAIL in_ready timeout: beat %0d never accepted", b);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    check("latency_out_valid", out_valid, 1);
    check("done_in_ready", in_ready, 0);
    collect();
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;

    vecs[0] = mk(1, 0, 4, 32'd5, 32'hFFFFFFFD, 32'h7FFFFFFF, 32'd2, 0, 32'h7FFFFFFF, 2, 0);
    vecs[1] = mk(1, 0, 2, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 32'd1, 1, 0);
    vecs[2] = mk(0, 0, 2, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 32'hFFFFFFFF, 0, 0);
    vecs[3] = mk(1, 1, 3, 32'd7, 32'hFFFFFFF8, 32'hFFFFFFF8, 0, 2, 32'hFFFFFFF8, 1, 0);
    vecs[4] = mk(0, 1, 4, 32'd10, 32'd3, 32'd3, 32'h80000000, 1, 32'd3, 1, 0);
    vecs[5] = mk(1, 1, 4, 32'd0, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 0, 32'h80000000, 1, 0);
    vecs[6] = mk(0, 0, 1, 32'd0, 0, 0, 0, 0, 32'd0, 0, 0);
    vecs[7] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0, 1);
    vecs[8] = mk(0, 0, 3, 32'd4, 32'd4, 32'd4, 0, 3, 32'd4, 0, 0);

    // Async reset state
    #2 reset_n = 1'b0;
    #1;
    check("reset_outputs", {busy, in_ready, out_valid, out_empty}, 0);
    check("reset_value", out_value, 0);
    check("reset_index", out_index, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 9; v++) begin
      for (int j = 0; j < 4; j++) stim[j] = vecs[v].d[j];
      run(vecs[v].sgn, vecs[v].mn, vecs[v].ln, vecs[v].gap, vecs[v].ev, vecs[v].ei, vecs[v].ee);
    end

    // Empty reduction under backpressure
    wait_idle();
    start = 1'b1; len = 8'd0; is_signed = 1'b1; is_min = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("empty_next_cycle_valid", out_valid, 1);
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_hold", {out_valid, out_empty, out_value, out_index}, {1'b1, 1'b1, 32'd0, 8'd0});
    end
    e.v = 32'd0; e.i = 8'd0; e.e = 1'b1;
    sb.push_back(e);
    collect();

    // start pulses while busy must not disturb the run
    wait_idle();
    start = 1'b1; len = 8'd2; is_signed = 1'b0; is_min = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    e.v = 32'd5; e.i = 8'd1; e.e = 1'b0;
    sb.push_back(e);
    in_valid = 1'b1; in_data = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    start = 1'b1; len = 8'd0; is_signed = 1'b1; is_min = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_in_accum_ignored", {busy, in_ready, out_valid}, 3'b110);
    in_valid = 1'b1; in_data = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("done_after_len_beats", out_valid, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_in_done_ignored", {out_valid, out_value}, {1'b1, 32'd5});
    collect();

    // Reset mid-accumulation discards the run
    wait_idle();
    start = 1'b1; len = 8'd4; is_signed = 1'b1; is_min = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'h55;
    @(posedge clk); #1;
    in_data = 32'h66;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrun_reset_flags", {busy, out_valid, in_ready}, 0);
    check("midrun_reset_value", out_value, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_valid_after_reset", {busy, out_valid}, 0);
    stim[0] = 32'd9;
    run(0, 0, 8'd1, 0, 32'd9, 8'd0, 1'b0);

    // Full-length run: counter must not wrap
    for (int j = 0; j < 255; j++) stim[j] = (j * 32'h9E3779B1) ^ 32'h00A5A5A5;
    e = model(1'b0, 1'b0, 255);
    run(0, 0, 8'd255, 0, e.v, e.i, e.e);
    e = model(1'b1, 1'b1, 255);
    run(1, 1, 8'd255, 0, e.v, e.i, e.e);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/maxmin_reducer.md
MAXMIN_REDUCER -- requirements
Module: maxmin_reducer

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter LEN_W, default 8, width of the length and index fields.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin a reduction; sampled only in IDLE.
REQ-006 len  input  LEN_W  number of elements in the reduction; latched on accepted start.
REQ-007 is_signed  input  1  1 = two's-complement compare, 0 = unsigned; latched on accepted start.
REQ-008 is_min  input  1  1 = track minimum, 0 = track maximum; latched on accepted start.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 in_valid  input  1  element-stream valid.
REQ-011 in_ready  output  1  element-stream ready.
REQ-012 in_data  input  WIDTH  element value.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  result consumer ready.
REQ-015 out_value  output  WIDTH  extreme value found.
REQ-016 out_index  output  LEN_W  0-based ordinal of the extreme element.
REQ-017 out_empty  output  1  high when the completed reduction had len = 0.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ACCUM, DONE.
REQ-019 IDLE: in_ready = 0, out_valid = 0; start = 1 latches len/is_signed/is_min; next state ACCUM if len != 0, else DONE with out_value = 0, out_index = 0, out_empty = 1.
REQ-020 start SHALL be ignored in ACCUM and DONE.
REQ-021 ACCUM: in_ready = 1; a beat is accepted iff in_valid && in_ready in the same cycle.
REQ-022 The first accepted beat SHALL load out_value unconditionally, with index 0 and out_empty = 0.
REQ-023 Each later beat SHALL replace the stored value and index only if strictly greater (max) or strictly less (min) under the latched compare mode; ties keep the earlier index.
REQ-024 The element counter SHALL increment once per accepted beat; after accepting beat number len, the next state is DONE and in_ready drops that same edge.
REQ-025 Latency: out_valid SHALL assert on the clock edge that accepts the last beat, i.e. visible the following cycle, with the final value already included.
REQ-026 in_valid gaps in ACCUM SHALL stall without altering state; any number of idle cycles is legal.
REQ-027 DONE: out_valid = 1, in_ready = 0, out_value/out_index/out_empty held stable until out_valid && out_ready, then next state IDLE.
REQ-028 Result registers SHALL retain their values in IDLE until the next accepted start.
REQ-029 len = 2^LEN_W-1 SHALL complete correctly; the counter SHALL NOT wrap within a reduction.
REQ-030 Compare SHALL be single-cycle combinational on full WIDTH bits; no truncation or extension of in_data.

Reset
REQ-031 reset_n low SHALL immediately force IDLE and clear busy, in_ready, out_valid, out_value, out_index, out_empty, the counter and latched modes to 0.
REQ-032 Reset asserted mid-ACCUM or mid-DONE SHALL discard the partial or pending result; no out_valid follows release.

Structure
REQ-033 A shared package SHALL hold the state enumeration (IDLE, ACCUM, DONE) and the default WIDTH/LEN_W constants.
REQ-034 One sub-module, ext_cmp, SHALL take a, b, is_signed, is_min and return a one-bit "b is strictly better than a" flag; the FSM and registers live in maxmin_reducer.

Verification
REQ-035 Signed max: is_signed=1, is_min=0, len=4, data 5, -3, 0x7FFFFFFF, 2 -> out_value 0x7FFFFFFF, out_index 2, out_empty 0.
REQ-036 Unsigned vs signed: len=2, data 0xFFFFFFFF, 1 -> signed max gives 1/index 1; unsigned max gives 0xFFFFFFFF/index 0.
REQ-037 Signed min with ties and stalls: len=3, data 7, -8, -8, in_valid gaps of 2 cycles -> out_value 0xFFFFFFF8, out_index 1.
REQ-038 Empty and backpressure: start len=0 -> out_valid the next cycle with out_empty 1, value 0; out_ready held low 5 cycles -> outputs stable, then handshake -> IDLE, busy 0.
REQ-039 Reset mid-run: len=4, reset_n low after 2 beats -> busy 0, out_valid 0; a new run with len=1, data 9 -> out_value 9, out_index 0.
REQ-040 start pulsed during ACCUM and DONE -> no effect on len, modes or result.
